// File: rtl/lc3_ctrl_fsm.sv
// LC-3 multi-cycle control unit: one Moore FSM that sequences fetch, decode,
// execute and memory access, with halt, illegal-opcode and memory-timeout reporting.
module lc3_ctrl_fsm #(
    parameter int MEM_TIMEOUT = 255,
    parameter int CNT_W       = 8
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       run,
    input  logic [3:0] ir_opcode,
    input  logic [2:0] ir_nzp,
    input  logic       ir_bit11,
    input  logic [2:0] cc_nzp,
    input  logic       mem_ready,
    output logic       ld_mar,
    output logic       ld_mdr,
    output logic       ld_ir,
    output logic       ld_pc,
    output logic       ld_reg,
    output logic       ld_cc,
    output logic       gate_pc,
    output logic       gate_mdr,
    output logic       gate_alu,
    output logic       gate_marmux,
    output logic [1:0] pc_mux,
    output logic       dr_r7,
    output logic       mem_en,
    output logic       mem_we,
    output logic       halted,
    output logic [1:0] err,
    output logic [3:0] state
);

    localparam logic [3:0] S_HALT      = 4'd0;
    localparam logic [3:0] S_FETCH0    = 4'd1;
    localparam logic [3:0] S_FETCH1    = 4'd2;
    localparam logic [3:0] S_FETCH2    = 4'd3;
    localparam logic [3:0] S_DECODE    = 4'd4;
    localparam logic [3:0] S_EXEC_ALU  = 4'd5;
    localparam logic [3:0] S_EXEC_BR   = 4'd6;
    localparam logic [3:0] S_EXEC_JMP  = 4'd7;
    localparam logic [3:0] S_EXEC_JSR  = 4'd8;
    localparam logic [3:0] S_EXEC_LEA  = 4'd9;
    localparam logic [3:0] S_ADDR_CALC = 4'd10;
    localparam logic [3:0] S_MEM_RD    = 4'd11;
    localparam logic [3:0] S_WB_LD     = 4'd12;
    localparam logic [3:0] S_ST_SETUP  = 4'd13;
    localparam logic [3:0] S_MEM_WR    = 4'd14;
    localparam logic [3:0] S_ERROR     = 4'd15;

    localparam logic [1:0] ERR_NONE    = 2'b00;
    localparam logic [1:0] ERR_ILLEGAL = 2'b01;
    localparam logic [1:0] ERR_TIMEOUT = 2'b10;

    localparam logic [1:0] PCMUX_INC  = 2'b00;
    localparam logic [1:0] PCMUX_OFFS = 2'b01;
    localparam logic [1:0] PCMUX_BASE = 2'b10;

    localparam logic [CNT_W-1:0] TIMEOUT_C = CNT_W'(MEM_TIMEOUT);
    localparam bit               WDOG_EN   = (MEM_TIMEOUT != 0);

    logic [3:0]       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             br_taken_q, br_taken_d;
    logic             jsr_imm_q, jsr_imm_d;
    logic [1:0]       err_q, err_d;

    logic             in_wait;
    logic [CNT_W-1:0] cnt_inc;
    logic             timeout;

    // A wait ends in timeout only when the limit is reached with mem_ready still low.
    assign in_wait = (state_q == S_FETCH1) || (state_q == S_MEM_RD) || (state_q == S_MEM_WR);
    assign cnt_inc = cnt_q + 1'b1;
    assign timeout = WDOG_EN && in_wait && !mem_ready && (cnt_inc == TIMEOUT_C);

    always_comb begin
        state_d    = state_q;
        br_taken_d = br_taken_q;
        jsr_imm_d  = jsr_imm_q;
        err_d      = err_q;
        cnt_d      = '0;
        if (in_wait && !mem_ready) begin
            cnt_d = cnt_inc;
        end

        case (state_q)
            S_HALT:      if (run) state_d = S_FETCH0;
            S_FETCH0:    state_d = S_FETCH1;
            S_FETCH1: begin
                if (mem_ready) begin
                    state_d = S_FETCH2;
                end else if (timeout) begin
                    state_d = S_ERROR;
                    err_d   = ERR_TIMEOUT;
                end
            end
            S_FETCH2:    state_d = S_DECODE;
            S_DECODE: begin
                // Branch outcome and JSR mode are latched so EXEC outputs stay pure Moore.
                br_taken_d = |(ir_nzp & cc_nzp);
                jsr_imm_d  = ir_bit11;
                case (ir_opcode)
                    4'b0001, 4'b0101, 4'b1001:           state_d = S_EXEC_ALU;
                    4'b0000:                             state_d = S_EXEC_BR;
                    4'b1100:                             state_d = S_EXEC_JMP;
                    4'b0100:                             state_d = S_EXEC_JSR;
                    4'b1110:                             state_d = S_EXEC_LEA;
                    4'b0010, 4'b0110, 4'b0011, 4'b0111:  state_d = S_ADDR_CALC;
                    4'b1111:                             state_d = S_HALT;
                    default: begin
                        state_d = S_ERROR;
                        err_d   = ERR_ILLEGAL;
                    end
                endcase
            end
            S_EXEC_ALU,
            S_EXEC_BR,
            S_EXEC_JMP,
            S_EXEC_JSR,
            S_EXEC_LEA,
            S_WB_LD:     state_d = S_FETCH0;
            // Opcode bit 0 separates loads (LD/LDR) from stores (ST/STR).
            S_ADDR_CALC: state_d = ir_opcode[0] ? S_ST_SETUP : S_MEM_RD;
            S_MEM_RD: begin
                if (mem_ready) begin
                    state_d = S_WB_LD;
                end else if (timeout) begin
                    state_d = S_ERROR;
                    err_d   = ERR_TIMEOUT;
                end
            end
            S_ST_SETUP:  state_d = S_MEM_WR;
            S_MEM_WR: begin
                if (mem_ready) begin
                    state_d = S_FETCH0;
                end else if (timeout) begin
                    state_d = S_ERROR;
                    err_d   = ERR_TIMEOUT;
                end
            end
            S_ERROR:     state_d = S_ERROR;
            default:     state_d = S_HALT;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_HALT;
            cnt_q      <= '0;
            br_taken_q <= 1'b0;
            jsr_imm_q  <= 1'b0;
            err_q      <= ERR_NONE;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            br_taken_q <= br_taken_d;
            jsr_imm_q  <= jsr_imm_d;
            err_q      <= err_d;
        end
    end

    always_comb begin
        ld_mar      = 1'b0;
        ld_mdr      = 1'b0;
        ld_ir       = 1'b0;
        ld_pc       = 1'b0;
        ld_reg      = 1'b0;
        ld_cc       = 1'b0;
        gate_pc     = 1'b0;
        gate_mdr    = 1'b0;
        gate_alu    = 1'b0;
        gate_marmux = 1'b0;
        pc_mux      = PCMUX_INC;
        dr_r7       = 1'b0;
        mem_en      = 1'b0;
        mem_we      = 1'b0;
        case (state_q)
            S_FETCH0: begin
                gate_pc = 1'b1;
                ld_mar  = 1'b1;
                ld_pc   = 1'b1;
            end
            S_FETCH1: begin
                mem_en = 1'b1;
                ld_mdr = 1'b1;
            end
            S_FETCH2: begin
                gate_mdr = 1'b1;
                ld_ir    = 1'b1;
            end
            S_EXEC_ALU: begin
                gate_alu = 1'b1;
                ld_reg   = 1'b1;
                ld_cc    = 1'b1;
            end
            S_EXEC_BR: begin
                if (br_taken_q) begin
                    ld_pc  = 1'b1;
                    pc_mux = PCMUX_OFFS;
                end
            end
            S_EXEC_JMP: begin
                ld_pc  = 1'b1;
                pc_mux = PCMUX_BASE;
            end
            S_EXEC_JSR: begin
                // R7 takes the old PC off the bus on the same edge PC is replaced.
                gate_pc = 1'b1;
                ld_reg  = 1'b1;
                dr_r7   = 1'b1;
                ld_pc   = 1'b1;
                pc_mux  = jsr_imm_q ? PCMUX_OFFS : PCMUX_BASE;
            end
            S_EXEC_LEA: begin
                gate_marmux = 1'b1;
                ld_reg      = 1'b1;
                ld_cc       = 1'b1;
            end
            S_ADDR_CALC: begin
                gate_marmux = 1'b1;
                ld_mar      = 1'b1;
            end
            S_MEM_RD: begin
                mem_en = 1'b1;
                ld_mdr = 1'b1;
            end
            S_WB_LD: begin
                gate_mdr = 1'b1;
                ld_reg   = 1'b1;
                ld_cc    = 1'b1;
            end
            S_ST_SETUP: begin
                gate_alu = 1'b1;
                ld_mdr   = 1'b1;
            end
            S_MEM_WR: begin
                mem_en = 1'b1;
                mem_we = 1'b1;
            end
            default: ;
        endcase
    end

    assign halted = (state_q == S_HALT) || (state_q == S_ERROR);
    assign err    = err_q;
    assign state  = state_q;

endmodule

// File: doc/lc3_ctrl_fsm.md
Name: lc3_ctrl_fsm

Overview:
Multi-cycle control unit for the LC-3 datapath. Sequences fetch, decode, address calculation, memory access and writeback. Drives the load enables, bus gates, PC mux and memory handshake from a registered state, and takes the IR opcode fields and condition codes as inputs. It replaces ad-hoc per-opcode control with a single Moore FSM, and adds halt, illegal-opcode and memory-timeout reporting.

Parameters:
MEM_TIMEOUT, 255, maximum cycles spent in any memory-wait state before aborting (0 = watchdog disabled)
CNT_W, 8, width of the wait-cycle counter; must hold MEM_TIMEOUT

Ports:
clk  input  1  system clock, rising-edge
rst_n  input  1  asynchronous active-low reset
run  input  1  level; in HALT, run=1 starts fetch on the next edge
ir_opcode  input  4  IR[15:12]
ir_nzp  input  3  IR[11:9], branch condition mask
ir_bit11  input  1  IR[11]; JSR=1 / JSRR=0
cc_nzp  input  3  current condition-code register
mem_ready  input  1  memory completion strobe
ld_mar, ld_mdr, ld_ir, ld_pc, ld_reg, ld_cc  output  1 each  register load enables
gate_pc, gate_mdr, gate_alu, gate_marmux  output  1 each  bus drivers; at most one high
pc_mux  output  2  00 PC+1, 01 PC+offset, 10 base register
dr_r7  output  1  force destination register to R7
mem_en  output  1  memory request
mem_we  output  1  write qualifier, valid only with mem_en
halted  output  1  high in HALT or ERROR
err  output  2  00 none, 01 illegal opcode, 10 memory timeout; sticky until reset
state  output  4  current state code, for debug

Behaviour:
- Reset (async, rst_n=0): state=HALT; every load, gate, mem and pc_mux output is 0; halted=1; err=00; counter=0; br_taken=0.
- All control outputs decode from registered state only (Moore). No input feeds an output combinationally.
- States and codes:
  - HALT(0): run=1 goes to FETCH0.
  - FETCH0(1): gate_pc, ld_mar, ld_pc, pc_mux=00. Goes to FETCH1.
  - FETCH1(2): mem_en, ld_mdr. Goes to FETCH2 when mem_ready=1.
  - FETCH2(3): gate_mdr, ld_ir. Goes to DECODE.
  - DECODE(4): no outputs. Registers br_taken = |(ir_nzp & cc_nzp). Dispatches on opcode:
    - 0001/0101/1001 go to EXEC_ALU.
    - 0000 goes to EXEC_BR.
    - 1100 goes to EXEC_JMP.
    - 0100 goes to EXEC_JSR.
    - 1110 goes to EXEC_LEA.
    - 0010/0110/0011/0111 go to ADDR_CALC.
    - 1111 goes to HALT.
    - 1000/1010/1011/1101 set err=01 and go to ERROR.
  - EXEC_ALU(5): gate_alu, ld_reg, ld_cc. Goes to FETCH0.
  - EXEC_BR(6): ld_pc and pc_mux=01 only if br_taken. Goes to FETCH0. nzp=000 is a no-op.
  - EXEC_JMP(7): ld_pc, pc_mux=10. Goes to FETCH0.
  - EXEC_JSR(8): gate_pc, ld_reg, dr_r7, ld_pc; pc_mux=01 if ir_bit11 else 10. R7 captures the old PC on the same edge that PC updates. Goes to FETCH0.
  - EXEC_LEA(9): gate_marmux, ld_reg, ld_cc. Goes to FETCH0.
  - ADDR_CALC(10): gate_marmux, ld_mar. Loads (0010/0110) go to MEM_RD; stores go to ST_SETUP.
  - MEM_RD(11): mem_en, ld_mdr. Goes to WB_LD when mem_ready=1.
  - WB_LD(12): gate_mdr, ld_reg, ld_cc. Goes to FETCH0.
  - ST_SETUP(13): gate_alu, ld_mdr (SR passthrough). Goes to MEM_WR.
  - MEM_WR(14): mem_en, mem_we. Goes to FETCH0 when mem_ready=1.
  - ERROR(15): halted=1. Stays in ERROR until reset; run is ignored.
- Memory handshake:
  - mem_ready is sampled only in FETCH1, MEM_RD and MEM_WR; it is ignored elsewhere.
  - mem_en stays high for the full wait.
  - The counter clears on entry to each wait state and increments each cycle that mem_ready=0.
  - When MEM_TIMEOUT≠0 and the counter reaches MEM_TIMEOUT with mem_ready still 0: err=10, go to ERROR.
  - mem_ready=1 on the same cycle the counter hits the limit counts as success.
- Latency with zero-wait memory (mem_ready=1 in the first wait cycle), from FETCH0 entry to the next FETCH0: ALU/BR/JMP/JSR/LEA 5 cycles; load 7; store 7.
- run is level-sensitive in HALT only; deasserting run mid-instruction has no effect. TRAP (1111) returns to HALT, so it halts when run=0 and restarts fetch when run=1.
- Async reset during any state, including mid-memory-wait, returns to the reset values immediately. mem_en drops with no completion.

Test Plan:
- Reset, then run=1, opcode 0001, mem_ready tied 1 → state 0→1→2→3→4→5→1. gate_alu, ld_reg, ld_cc high only in state 5. halted=0 after the first edge.
- Opcode 0000 with ir_nzp=010: first with cc_nzp=010 → ld_pc=1, pc_mux=01 in EXEC_BR. Then with cc_nzp=100 → ld_pc=0.
- Opcode 0010 with mem_ready delayed 3 cycles in MEM_RD → mem_en high 4 cycles. ld_mdr is captured on the ready cycle. WB_LD follows; total 10 cycles.
- Opcode 0011 → ADDR_CALC, ST_SETUP, MEM_WR with mem_en=mem_we=1 until mem_ready. Returns to FETCH0; ld_reg never asserted.
- Opcode 1101 → err=01, halted=1, state=15; a run toggle keeps state 15. MEM_TIMEOUT=4 with mem_ready held 0 in FETCH1 → err=10 after 4 wait cycles.
- Opcode 1111 with run=0 → returns to HALT, halted=1. Assert rst_n=0 mid-MEM_WR → all outputs zero, state=0 without a clock edge.
